// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: reset/base addresses, the NOP word,
// instruction field positions and the opcode/funct values used by decode.
package mips_defs;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int          IM_AW    = 12;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   localparam logic [5:0] OP_RTYPE   = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   // True for instructions that write the D_pc+8 link address.
   function automatic logic is_link(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OP_JAL) || ((opcode == OP_RTYPE) && (funct == FUNCT_JALR));
   endfunction

endpackage

// File: rtl/f_d_pipe_reg.sv
// F/D pipeline register. Priority: flush (bubble) > stall/!en (hold) > load.
module f_d_pipe_reg
   import mips_defs::*;
#(
   parameter logic [31:0] PC_RESET_VAL = mips_defs::PC_RESET
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        stall,
   input  logic        en,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        in_adel,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        valid,
   output logic        adel
);

   // Synchronous active-low reset, then bubble, hold or load the slot.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instr <= NOP;
         pc    <= PC_RESET_VAL;
         valid <= 1'b0;
         adel  <= 1'b0;
      end else if (flush) begin
         instr <= NOP;
         pc    <= in_pc;
         valid <= 1'b0;
         adel  <= 1'b0;
      end else if (stall || !en) begin
         instr <= instr;
         pc    <= pc;
         valid <= valid;
         adel  <= adel;
      end else begin
         instr <= in_instr;
         pc    <= in_pc;
         valid <= 1'b1;
         adel  <= in_adel;
      end
   end

endmodule

// File: rtl/f_d_fetch_stage.sv
// Fetch stage: PC register, next-PC selection, instruction-memory range
// check, the F/D register and D-stage field decode.
module f_d_fetch_stage #(
   parameter logic [31:0] PC_RESET = mips_defs::PC_RESET,
   parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
   parameter int          IM_AW    = mips_defs::IM_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             redirect,
   input  logic [31:0]      redirect_pc,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_rdata,
   output logic [31:0]      F_pc,
   output logic [31:0]      D_instr,
   output logic [31:0]      D_pc,
   output logic [31:0]      D_pc8,
   output logic             D_valid,
   output logic             D_adel,
   output logic [15:0]      D_imm16,
   output logic [4:0]       D_rs,
   output logic [4:0]       D_rt,
   output logic [4:0]       D_rd,
   output logic [5:0]       D_opcode,
   output logic [5:0]       D_funct
);

   import mips_defs::*;

   logic [31:0] im_offset;
   logic        bad;
   logic [31:0] fetched;

   // PC register: stall holds, redirect jumps, otherwise step one word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         F_pc <= PC_RESET;
      end else if (stall) begin
         F_pc <= F_pc;
      end else if (redirect) begin
         F_pc <= redirect_pc;
      end else begin
         F_pc <= F_pc + 32'd4;
      end
   end

   // Misaligned or out-of-range fetches are replaced by NOP and flagged.
   always_comb begin
      im_offset = F_pc - IM_BASE;
      bad       = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) ||
                  (im_offset >= (32'd4 << IM_AW));
      fetched   = bad ? NOP : im_rdata;
      im_addr   = im_offset[IM_AW+1:2];
   end

   f_d_pipe_reg #(
      .PC_RESET_VAL (PC_RESET)
   ) u_fd_reg (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .stall    (stall),
      .en       (1'b1),
      .in_instr (fetched),
      .in_pc    (F_pc),
      .in_adel  (bad),
      .instr    (D_instr),
      .pc       (D_pc),
      .valid    (D_valid),
      .adel     (D_adel)
   );

   // D-stage field slicing and link address.
   always_comb begin
      D_pc8    = D_pc + 32'd8;
      D_imm16  = D_instr[IMM_MSB:IMM_LSB];
      D_rs     = D_instr[RS_MSB:RS_LSB];
      D_rt     = D_instr[RT_MSB:RT_LSB];
      D_rd     = D_instr[RD_MSB:RD_LSB];
      D_opcode = D_instr[OPCODE_MSB:OPCODE_LSB];
      D_funct  = D_instr[FUNCT_MSB:FUNCT_LSB];
   end

endmodule

// File: tb/tb_f_d_fetch_stage.sv
// Directed testbench for f_d_fetch_stage with a behavioural instruction ROM.
module tb_f_d_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [11:0] im_addr;
   logic [31:0] im_rdata;
   logic [31:0] F_pc;
   logic [31:0] D_instr;
   logic [31:0] D_pc;
   logic [31:0] D_pc8;
   logic        D_valid;
   logic        D_adel;
   logic [15:0] D_imm16;
   logic [4:0]  D_rs;
   logic [4:0]  D_rt;
   logic [4:0]  D_rd;
   logic [5:0]  D_opcode;
   logic [5:0]  D_funct;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   f_d_fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .im_addr     (im_addr),
      .im_rdata    (im_rdata),
      .F_pc        (F_pc),
      .D_instr     (D_instr),
      .D_pc        (D_pc),
      .D_pc8       (D_pc8),
      .D_valid     (D_valid),
      .D_adel      (D_adel),
      .D_imm16     (D_imm16),
      .D_rs        (D_rs),
      .D_rt        (D_rt),
      .D_rd        (D_rd),
      .D_opcode    (D_opcode),
      .D_funct     (D_funct)
   );

   // Distinctive ROM contents so each word address is recognisable.
   function automatic logic [31:0] romWord(input logic [11:0] a);
      return {6'h23, a[4:0], ~a[4:0], a ^ 12'h5A5, a[3:0]};
   endfunction

   // Expected ROM word for an in-range, aligned PC.
   function automatic logic [31:0] wordFor(input logic [31:0] pc);
      logic [31:0] off;
      off = (pc - 32'h0000_3000) >> 2;
      return romWord(off[11:0]);
   endfunction

   always_comb im_rdata = romWord(im_addr);

   task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks PC, F/D state and every derived decode output.
   task automatic checkOutput(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                              input logic [31:0] instr, input logic valid, input logic adel);
      logic [31:0] off;
      off = fpc - 32'h0000_3000;
      check32({tag, ".F_pc"}, F_pc, fpc);
      check32({tag, ".im_addr"}, {20'h0, im_addr}, {20'h0, off[13:2]});
      check32({tag, ".D_pc"}, D_pc, dpc);
      check32({tag, ".D_pc8"}, D_pc8, dpc + 32'd8);
      check32({tag, ".D_instr"}, D_instr, instr);
      check32({tag, ".D_valid"}, {31'h0, D_valid}, {31'h0, valid});
      check32({tag, ".D_adel"}, {31'h0, D_adel}, {31'h0, adel});
      check32({tag, ".fields"}, {D_opcode, D_rs, D_rt, D_imm16}, instr);
      check32({tag, ".rd_funct"}, {21'h0, D_rd, D_funct}, {21'h0, instr[15:11], instr[5:0]});
   endtask

   task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                                input logic rdr, input logic [31:0] rpc);
      reset       = rst;
      stall       = stl;
      flush       = fls;
      redirect    = rdr;
      redirect_pc = rpc;
      tick();
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

      // Reset held two cycles
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("reset", 32'h3000, 32'h3000, 32'h0, 0, 0);

      // Sequential fetch
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("seq0", 32'h3004, 32'h3000, wordFor(32'h3000), 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("seq1", 32'h3008, 32'h3004, wordFor(32'h3004), 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("seq3", 32'h3010, 32'h300C, wordFor(32'h300C), 1, 0);

      // Stall for three cycles at 0x3010
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 0, 0, 0);
         checkOutput("stall", 32'h3010, 32'h300C, wordFor(32'h300C), 1, 0);
      end
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("unstall", 32'h3014, 32'h3010, wordFor(32'h3010), 1, 0);

      // Redirect with delay slot
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("preredir", 32'h3020, 32'h301C, wordFor(32'h301C), 1, 0);
      applyStimulus(1, 0, 0, 1, 32'h3100);
      checkOutput("slot", 32'h3100, 32'h3020, wordFor(32'h3020), 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("target", 32'h3104, 32'h3100, wordFor(32'h3100), 1, 0);

      // Redirect ignored while stalled
      applyStimulus(1, 1, 0, 1, 32'h3200);
      checkOutput("stallredir", 32'h3104, 32'h3100, wordFor(32'h3100), 1, 0);

      // Flush with stall, then flush alone, then normal
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("flushstall", 32'h3104, 32'h3104, 32'h0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("flush", 32'h3108, 32'h3104, 32'h0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("postflush", 32'h310C, 32'h3108, wordFor(32'h3108), 1, 0);

      // Bad fetch addresses and the top-of-ROM boundary
      applyStimulus(1, 0, 0, 1, 32'h3002);
      checkOutput("toMisal", 32'h3002, 32'h310C, wordFor(32'h310C), 1, 0);
      applyStimulus(1, 0, 0, 1, 32'h2FFC);
      checkOutput("misal", 32'h2FFC, 32'h3002, 32'h0, 1, 1);
      applyStimulus(1, 0, 0, 1, 32'h7000);
      checkOutput("below", 32'h7000, 32'h2FFC, 32'h0, 1, 1);
      applyStimulus(1, 0, 0, 1, 32'h6FFC);
      checkOutput("above", 32'h6FFC, 32'h7000, 32'h0, 1, 1);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("lastword", 32'h7000, 32'h6FFC, wordFor(32'h6FFC), 1, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("pastend", 32'h7004, 32'h7000, 32'h0, 1, 1);

      // 32-bit wrap of PC and link address
      applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFC);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("wrap", 32'h0000_0000, 32'hFFFF_FFFC, 32'h0, 1, 1);

      // Reset mid-stall with redirect asserted
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 32'h3300);
      checkOutput("midreset", 32'h3000, 32'h3000, 32'h0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("restart", 32'h3004, 32'h3000, wordFor(32'h3000), 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
